// File: rtl/timer_alarm_scheduler.sv
// timer_alarm_scheduler: shares one 64-bit timer compare between CHANNELS
// software alarms. The compare always holds the earliest armed deadline, or
// all-ones when nothing is armed.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// PARK_LO  | write CMP_LO = all-ones
// PARK_HI  | write CMP_HI = all-ones
// IDLE     | compare parked; wait for a rescan request
// SCAN     | examine one channel per cycle, keep earliest armed deadline
// RD_HI    | sample VAL_HI
// RD_LO    | sample VAL_LO
// RD_HI2   | sample VAL_HI again; a change means LO carried, so re-read
// CHECK    | fire at once if the deadline is too close, else program it
// WR_PARK  | CMP_HI = all-ones so no half-written compare can match
// WR_LO    | CMP_LO = deadline low word
// WR_HI    | CMP_HI = deadline high word
// WAIT     | wait for compare match or a rescan request
module timer_alarm_scheduler #(
    parameter int CHANNELS    = 4,
    parameter int PROG_MARGIN = 8,
    parameter int ADDR_W      = $clog2(2*CHANNELS+2)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] write_address_i,
    input  logic [31:0]       write_data_i,
    input  logic              read_i,
    input  logic [ADDR_W-1:0] read_address_i,
    output logic [31:0]       read_data_o,
    output logic              interrupt_o,
    output logic              timer_write_o,
    output logic [1:0]        timer_write_address_o,
    output logic [31:0]       timer_write_data_o,
    output logic [1:0]        timer_read_address_o,
    input  logic [31:0]       timer_read_data_i,
    input  logic              timer_interrupt_i
);
    localparam int                IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [ADDR_W-1:0] ARM_ADDR  = ADDR_W'(2*CHANNELS);
    localparam logic [ADDR_W-1:0] PEND_ADDR = ADDR_W'(2*CHANNELS+1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CHANNELS-1);
    localparam logic [64:0]       MARGIN    = 65'(PROG_MARGIN);
    localparam logic [1:0]        CMP_LO = 2'd0, CMP_HI = 2'd1, VAL_LO = 2'd2, VAL_HI = 2'd3;

    typedef enum logic [3:0] {
        S_PARK_LO, S_PARK_HI, S_IDLE, S_SCAN, S_RD_HI, S_RD_LO, S_RD_HI2,
        S_CHECK, S_WR_PARK, S_WR_LO, S_WR_HI, S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [63:0]         deadline_q [CHANNELS];
    logic [63:0]         deadline_d [CHANNELS];
    logic [CHANNELS-1:0] armed_q, armed_d, pending_q, pending_d, fire_vec;
    logic                rescan_q, rescan_d, rescan_set;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d, min_idx_q, min_idx_d;
    logic                min_valid_q, min_valid_d;
    logic [63:0]         min_dl_q, min_dl_d, now_q, now_d;
    logic [31:0]         hi1_q, hi1_d, lo_q, lo_d;
    logic                fire, scan_entry;
    logic                wr_dl, wr_arm, wr_pend;
    logic [IDX_W-1:0]    wr_ch, rd_ch;
    logic [63:0]         rd_dl;

    assign wr_dl      = write_i && (write_address_i < ARM_ADDR);
    assign wr_arm     = write_i && (write_address_i == ARM_ADDR);
    assign wr_pend    = write_i && (write_address_i == PEND_ADDR);
    assign wr_ch      = IDX_W'(write_address_i >> 1);
    assign rd_ch      = IDX_W'(read_address_i >> 1);
    assign rescan_set = wr_arm || (wr_dl && armed_q[wr_ch]);
    assign interrupt_o = |pending_q;

    // Bus-side register updates; a fire loses to an ARM write but beats a pending clear
    always_comb begin
        fire_vec = fire ? (CHANNELS'(1) << min_idx_q) : '0;
        for (int c = 0; c < CHANNELS; c++) begin
            deadline_d[c] = deadline_q[c];
            if (wr_dl && (wr_ch == IDX_W'(c))) begin
                if (write_address_i[0]) deadline_d[c][63:32] = write_data_i;
                else                    deadline_d[c][31:0]  = write_data_i;
            end
        end
        armed_d   = wr_arm ? write_data_i[CHANNELS-1:0] : (armed_q & ~fire_vec);
        pending_d = (wr_pend ? (pending_q & ~write_data_i[CHANNELS-1:0]) : pending_q) | fire_vec;
        // a scan starting this edge already sees any write landing on the same edge
        rescan_d  = scan_entry ? 1'b0 : (rescan_q || rescan_set);
    end

    // Combinational register read-back
    always_comb begin
        read_data_o = '0;
        rd_dl       = deadline_q[rd_ch];
        if (read_i) begin
            if (read_address_i < ARM_ADDR)       read_data_o = read_address_i[0] ? rd_dl[63:32] : rd_dl[31:0];
            else if (read_address_i == ARM_ADDR)  read_data_o = 32'(armed_q);
            else if (read_address_i == PEND_ADDR) read_data_o = 32'(pending_q);
        end
    end

    // Scheduler FSM: next state, scan/snapshot datapath and timer port drive
    always_comb begin
        state_d     = state_q;
        scan_idx_d  = scan_idx_q;
        min_idx_d   = min_idx_q;
        min_dl_d    = min_dl_q;
        min_valid_d = min_valid_q;
        hi1_d       = hi1_q;
        lo_d        = lo_q;
        now_d       = now_q;
        fire        = 1'b0;
        timer_write_o         = 1'b0;
        timer_write_address_o = CMP_LO;
        timer_write_data_o    = '0;
        timer_read_address_o  = CMP_LO;
        case (state_q)
            S_PARK_LO: begin
                timer_write_o = 1'b1; timer_write_address_o = CMP_LO; timer_write_data_o = '1;
                state_d = S_PARK_HI;
            end
            S_PARK_HI: begin
                timer_write_o = 1'b1; timer_write_address_o = CMP_HI; timer_write_data_o = '1;
                state_d = S_IDLE;
            end
            S_IDLE: if (rescan_q || rescan_set) state_d = S_SCAN;
            S_SCAN: begin
                if (armed_q[scan_idx_q] && (!min_valid_q || (deadline_q[scan_idx_q] < min_dl_q))) begin
                    min_valid_d = 1'b1;
                    min_dl_d    = deadline_q[scan_idx_q];
                    min_idx_d   = scan_idx_q;
                end
                if (scan_idx_q == LAST_IDX) state_d = min_valid_d ? S_RD_HI : S_PARK_LO;
                else                        scan_idx_d = scan_idx_q + 1'b1;
            end
            S_RD_HI: begin
                timer_read_address_o = VAL_HI; hi1_d = timer_read_data_i; state_d = S_RD_LO;
            end
            S_RD_LO: begin
                timer_read_address_o = VAL_LO; lo_d = timer_read_data_i; state_d = S_RD_HI2;
            end
            S_RD_HI2: begin
                timer_read_address_o = VAL_HI;
                if (timer_read_data_i != hi1_q) state_d = S_RD_HI;
                else begin
                    now_d   = {hi1_q, lo_q};
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ({1'b0, min_dl_q} <= ({1'b0, now_q} + MARGIN)) begin
                    fire    = 1'b1;
                    state_d = S_SCAN;
                end else state_d = S_WR_PARK;
            end
            S_WR_PARK: begin
                timer_write_o = 1'b1; timer_write_address_o = CMP_HI; timer_write_data_o = '1;
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                timer_write_o = 1'b1; timer_write_address_o = CMP_LO; timer_write_data_o = min_dl_q[31:0];
                state_d = S_WR_HI;
            end
            S_WR_HI: begin
                timer_write_o = 1'b1; timer_write_address_o = CMP_HI; timer_write_data_o = min_dl_q[63:32];
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timer_interrupt_i) begin
                    fire    = 1'b1;
                    state_d = S_SCAN;
                end else if (rescan_q || rescan_set) state_d = S_SCAN;
            end
            default: state_d = S_PARK_LO;
        endcase
        scan_entry = (state_d == S_SCAN) && (state_q != S_SCAN);
        if (scan_entry) begin
            scan_idx_d  = '0;
            min_valid_d = 1'b0;
        end
        if (rst_i) begin
            fire                  = 1'b0;
            timer_write_o         = 1'b0;
            timer_write_address_o = CMP_LO;
            timer_write_data_o    = '0;
            timer_read_address_o  = CMP_LO;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_PARK_LO;
            for (int c = 0; c < CHANNELS; c++) deadline_q[c] <= '1;
            armed_q     <= '0;
            pending_q   <= '0;
            rescan_q    <= 1'b0;
            scan_idx_q  <= '0;
            min_idx_q   <= '0;
            min_valid_q <= 1'b0;
            min_dl_q    <= '0;
            now_q       <= '0;
            hi1_q       <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            for (int c = 0; c < CHANNELS; c++) deadline_q[c] <= deadline_d[c];
            armed_q     <= armed_d;
            pending_q   <= pending_d;
            rescan_q    <= rescan_d;
            scan_idx_q  <= scan_idx_d;
            min_idx_q   <= min_idx_d;
            min_valid_q <= min_valid_d;
            min_dl_q    <= min_dl_d;
            now_q       <= now_d;
            hi1_q       <= hi1_d;
            lo_q        <= lo_d;
        end
    end
endmodule

// File: doc/timer_alarm_scheduler.md
Name: timer_alarm_scheduler

Overview:
- Multiplexes one 64-bit timer/compare peripheral between CHANNELS software alarms.
- Sits between the bus-side register interface and the timer's write and read ports.
- Holds one 64-bit deadline per channel and programs the earliest armed deadline into the timer compare registers.
- On compare match (or an already-passed deadline) sets that channel's pending bit and reschedules.

Parameters:
CHANNELS, 4, number of alarm channels (2..8)
PROG_MARGIN, 8, minimum cycles between the time snapshot and the deadline for the compare to be programmed; otherwise the alarm fires immediately
ADDR_W, $clog2(2*CHANNELS+2), register address width (derived)

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  reset, synchronous, active-high
write_i  in  1  register write strobe
write_address_i  in  ADDR_W  write address
write_data_i  in  32  write data
read_i  in  1  register read strobe
read_address_i  in  ADDR_W  read address
read_data_o  out  32  combinational read data
interrupt_o  out  1  level; OR of all pending bits
timer_write_o  out  1  write strobe to timer
timer_write_address_o  out  2  0=CMP_LO, 1=CMP_HI, 2=VAL_LO, 3=VAL_HI
timer_write_data_o  out  32  timer write data
timer_read_address_o  out  2  timer read address
timer_read_data_i  in  32  timer read data (combinational from address)
timer_interrupt_i  in  1  timer compare match (timer halts while asserted)

Behaviour:
- Register map:
  - 2c = DEADLINE_LO[c], 2c+1 = DEADLINE_HI[c].
  - 2*CHANNELS = ARM (bit c; a write replaces the armed vector).
  - 2*CHANNELS+1 = PENDING (read; write-1-to-clear).
  - Unmapped reads return 0.
- Reset values:
  - Deadlines all-ones; armed, pending = 0.
  - interrupt_o, timer_write_o, timer_write_address_o, timer_write_data_o, timer_read_address_o = 0.
  - FSM = PARK_LO.
- Rescan trigger: any ARM write, or a DEADLINE write to an armed channel, sets rescan_req. rescan_req is cleared on entry to SCAN.
- FSM:
  - PARK_LO / PARK_HI: write 0xFFFFFFFF to CMP_LO then CMP_HI, one cycle each. Then IDLE.
  - IDLE: if rescan_req, go to SCAN.
  - SCAN: evaluates one channel per cycle (CHANNELS cycles). Tracks the minimum armed deadline and its index; ties go to the lowest index. If no channel is armed, go to PARK_LO. Otherwise go to RD_HI.
  - RD_HI, RD_LO, RD_HI2: read VAL_HI, VAL_LO, VAL_HI into hi1, lo, hi2. If hi2 != hi1, return to RD_HI (torn-read retry). Else now = {hi1, lo}; go to CHECK.
  - CHECK: 64-bit unsigned compare. If min_deadline <= now + PROG_MARGIN, fire the target and go to SCAN. Else go to WR_PARK.
  - WR_PARK: write CMP_HI = 0xFFFFFFFF, so no transient compare equals the timer.
  - WR_LO: write CMP_LO = deadline[31:0].
  - WR_HI: write CMP_HI = deadline[63:32]. Then WAIT.
  - WAIT: on timer_interrupt_i, fire the target and go to SCAN. Else if rescan_req, go to SCAN. Fire takes priority over rescan.
- Fire(c):
  - pending[c] <= 1, armed[c] <= 0.
  - An ARM write in the same cycle wins for armed (armed = written value).
  - Pending set wins over a same-cycle PENDING clear of that bit.
- Write timing:
  - timer_write_o is asserted only in the PARK_* and WR_* states, exactly one cycle per write.
  - The timer value registers are never written.
- Read timing: timer_read_address_o is meaningful only in the RD_* states; it is 0 otherwise.
- timer_interrupt_i outside WAIT is ignored. This covers a timer halted at all-ones after wrap.
- Latency: arm to compare programmed = CHANNELS + 3 + 1 + 3 cycles from the cycle after the write, with no retry. For CHANNELS=4 that is 11 cycles.
- A mid-operation reset aborts any sequence, discards target and snapshot, and re-parks the compare.
- Bus register reads/writes are always accepted in one cycle; there is no backpressure.

Test Plan:
- Reset, then idle: first two cycles write CMP_LO=FFFFFFFF and CMP_HI=FFFFFFFF; then no timer writes; interrupt_o=0; PENDING reads 0.
- Timer at 100; DEADLINE[2]=1000; ARM=0x4 -> writes CMP_HI=FFFFFFFF, CMP_LO=1000, CMP_HI=0. Drive timer_interrupt_i at 1000 -> PENDING=0x4, ARM reads 0, interrupt_o=1. Write PENDING=0x4 -> interrupt_o=0.
- DEADLINE[0]=5000, DEADLINE[1]=3000, DEADLINE[3]=3000; ARM=0xB -> compare programmed to 3000 for channel 1. Match -> PENDING=0x2. Channel 3 is then past the deadline and fires from CHECK without compare reprogramming -> PENDING=0xA. Next compare = 5000.
- Timer at 10000; DEADLINE[0]=10005 (within PROG_MARGIN) -> immediate fire, no CMP_LO write.
- Torn read: timer_read_data_i returns HI=0, LO=FFFFFFFF, HI=1 -> FSM retries RD_HI and uses the consistent second sample.
- In WAIT on channel 0 (deadline 8000), rewrite DEADLINE_LO[0]=4000 -> rescan, compare reprogrammed to 4000. Same-cycle timer_interrupt_i plus PENDING clear of bit 0 -> bit 0 remains set.
